// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU: quotient to LO (r), remainder to HI (r2).
// Works on operand magnitudes and applies the signs in a final fix-up cycle.
module div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sgn,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] r,
  output logic [WIDTH-1:0] r2,
  output logic             dz
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] araw;
  logic             negq;
  logic             negr;
  logic             zdiv;

  logic [WIDTH-1:0] amag;
  logic [WIDTH-1:0] bmag;
  logic [WIDTH:0]   sh;
  logic [WIDTH-1:0] diff;
  logic             fit;

  // |x| of the most negative value is 2^(WIDTH-1), which still fits the unsigned datapath.
  assign amag = (sgn && a[WIDTH-1]) ? -a : a;
  assign bmag = (sgn && b[WIDTH-1]) ? -b : b;

  // Restoring step: the shifted partial remainder is WIDTH+1 bits wide; if its top bit is set it
  // already exceeds any divisor, and the low-bit difference is then the exact new remainder.
  assign sh   = {rem, quo[WIDTH-1]};
  assign diff = sh[WIDTH-1:0] - dvs;
  assign fit  = sh[WIDTH] || (sh[WIDTH-1:0] >= dvs);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      rem   <= '0;
      quo   <= '0;
      dvs   <= '0;
      araw  <= '0;
      negq  <= 1'b0;
      negr  <= 1'b0;
      zdiv  <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      r     <= '0;
      r2    <= '0;
      dz    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            araw  <= a;
            quo   <= amag;
            dvs   <= bmag;
            rem   <= '0;
            negq  <= sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
            negr  <= sgn & a[WIDTH-1];
            zdiv  <= (b == '0);
            cnt   <= CW'(WIDTH - 1);
            busy  <= 1'b1;
            state <= (b == '0) ? FIX : CALC;
          end
        end
        CALC: begin
          rem <= fit ? diff : sh[WIDTH-1:0];
          quo <= {quo[WIDTH-2:0], fit};
          cnt <= cnt - CW'(1);
          if (cnt == '0) begin
            state <= FIX;
          end
        end
        FIX: begin
          if (zdiv) begin
            r  <= '1;
            r2 <= araw;
            dz <= 1'b1;
          end else begin
            r  <= negq ? -quo : quo;
            r2 <= negr ? -rem : rem;
            dz <= 1'b0;
          end
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: transaction-level reference model checked every cycle,
// plus directed cases with hand-computed results and randomized operands.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        sgn;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] r;
  logic [31:0] r2;
  logic        dz;

  int n_cmp = 0;
  int n_mis = 0;

  div_unit #(.WIDTH(32)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .sgn  (sgn),
    .a    (a),
    .b    (b),
    .busy (busy),
    .done (done),
    .r    (r),
    .r2   (r2),
    .dz   (dz)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Reference division from plain 64-bit arithmetic (truncating quotient, dividend-signed remainder).
  function automatic void ref_div(input logic s, input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] q, output logic [31:0] rm, output logic z);
    longint lx;
    longint ly;
    if (y == 32'd0) begin
      q  = 32'hFFFF_FFFF;
      rm = x;
      z  = 1'b1;
    end else begin
      lx = s ? longint'($signed(x)) : longint'({32'd0, x});
      ly = s ? longint'($signed(y)) : longint'({32'd0, y});
      q  = 32'(lx / ly);
      rm = 32'(lx % ly);
      z  = 1'b0;
    end
  endfunction

  // Transaction model: an accepted start produces its result a fixed number of edges later.
  int          m_left = 0;
  bit          armed  = 1'b0;
  logic        m_busy = 1'b0;
  logic        m_done = 1'b0;
  logic        m_dz   = 1'b0;
  logic [31:0] m_r    = '0;
  logic [31:0] m_r2   = '0;
  logic [31:0] p_r;
  logic [31:0] p_r2;
  logic        p_dz;

  always @(posedge clk) begin
    m_done = 1'b0;
    if (rst) begin
      armed  = 1'b1;
      m_left = 0;
      m_busy = 1'b0;
      m_r    = '0;
      m_r2   = '0;
      m_dz   = 1'b0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_busy = 1'b0;
        m_done = 1'b1;
        m_r    = p_r;
        m_r2   = p_r2;
        m_dz   = p_dz;
      end
    end else if (start) begin
      ref_div(sgn, a, b, p_r, p_r2, p_dz);
      m_busy = 1'b1;
      m_left = (b == 32'd0) ? 1 : 33;
    end
    #1;
    if (armed) begin
      chk("cyc_busy", 32'(busy), 32'(m_busy));
      chk("cyc_done", 32'(done), 32'(m_done));
      chk("cyc_r",    r,         m_r);
      chk("cyc_r2",   r2,        m_r2);
      chk("cyc_dz",   32'(dz),   32'(m_dz));
    end
  end

  // Called at a negedge; leaves start high across exactly one rising edge, then scrambles operands.
  task automatic start_op(input logic s, input logic [31:0] x, input logic [31:0] y);
    start = 1'b1;
    sgn   = s;
    a     = x;
    b     = y;
    @(negedge clk);
    start = 1'b0;
    sgn   = 1'($urandom_range(0, 1));
    a     = $urandom;
    b     = $urandom;
  endtask

  // Counts edges since the start edge (cyc0 already elapsed) until done, with a bounded wait.
  task automatic wait_done(input string nm, input int cyc0, input int lat,
                           input logic [31:0] er, input logic [31:0] er2, input logic edz);
    int cyc;
    int bcnt;
    cyc  = cyc0;
    bcnt = 0;
    while (done !== 1'b1 && cyc < 80) begin
      if (busy === 1'b1) bcnt++;
      @(negedge clk);
      cyc++;
    end
    if (done !== 1'b1) begin
      n_cmp++;
      n_mis++;
      $display("FAIL %s_timeout: no done after %0d edges, expected at %0d", nm, cyc, lat);
    end else begin
      chk({nm, "_lat"}, 32'(cyc), 32'(lat));
      if (cyc0 == 1) chk({nm, "_busycyc"}, 32'(bcnt), 32'(lat - 1));
      chk({nm, "_r"},  r,        er);
      chk({nm, "_r2"}, r2,       er2);
      chk({nm, "_dz"}, 32'(dz),  32'(edz));
    end
  endtask

  task automatic run_op(input string nm, input logic s, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] er, input logic [31:0] er2, input logic edz);
    start_op(s, x, y);
    wait_done(nm, 1, (y == 32'd0) ? 2 : 34, er, er2, edz);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] q;
    logic [31:0] rm;
    logic        z;
    logic        s;
    int          dn;

    rst   = 1'b1;
    start = 1'b0;
    sgn   = 1'b0;
    a     = '0;
    b     = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_r",    r,         32'd0);
    chk("rst_r2",   r2,        32'd0);
    chk("rst_dz",   32'(dz),   32'd0);
    rst = 1'b0;
    @(negedge clk);

    run_op("u_basic",  1'b0, 32'd100,         32'd7,           32'd14,          32'd2,  1'b0);
    run_op("s_neg_a",  1'b1, 32'hFFFF_FFF9,   32'd2,           32'hFFFF_FFFD,   32'hFFFF_FFFF, 1'b0);
    run_op("s_neg_b",  1'b1, 32'd7,           32'hFFFF_FFFE,   32'hFFFF_FFFD,   32'd1,  1'b0);
    run_op("s_neg_ab", 1'b1, 32'hFFFF_FFF9,   32'hFFFF_FFFE,   32'd3,           32'hFFFF_FFFF, 1'b0);
    run_op("u_max",    1'b0, 32'hFFFF_FFFF,   32'd1,           32'hFFFF_FFFF,   32'd0,  1'b0);
    run_op("s_ovf",    1'b1, 32'h8000_0000,   32'hFFFF_FFFF,   32'h8000_0000,   32'd0,  1'b0);
    run_op("u_small",  1'b0, 32'd5,           32'd9,           32'd0,           32'd5,  1'b0);
    run_op("dz_u",     1'b0, 32'd1234,        32'd0,           32'hFFFF_FFFF,   32'd1234, 1'b1);
    run_op("dz_s",     1'b1, 32'd1234,        32'd0,           32'hFFFF_FFFF,   32'd1234, 1'b1);
    run_op("dz_clear", 1'b0, 32'd100,         32'd7,           32'd14,          32'd2,  1'b0);

    // Start pulsed mid-operation must be ignored.
    start_op(1'b1, 32'hFFFF_FF9C, 32'd7);
    repeat (5) @(negedge clk);
    start = 1'b1;
    sgn   = 1'b0;
    a     = 32'd50;
    b     = 32'd5;
    @(negedge clk);
    start = 1'b0;
    wait_done("ign_start", 7, 34, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0);

    // Start in the done cycle is accepted.
    start_op(1'b0, 32'd1000, 32'd10);
    wait_done("bb_first", 1, 34, 32'd100, 32'd0, 1'b0);
    start_op(1'b0, 32'd77, 32'd8);
    wait_done("bb_second", 1, 34, 32'd9, 32'd5, 1'b0);

    // Reset asserted at edge E10 aborts the operation.
    start_op(1'b0, 32'd1000, 32'd3);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_r",    r,         32'd0);
    chk("abort_r2",   r2,        32'd0);
    chk("abort_dz",   32'(dz),   32'd0);
    dn = 0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) dn++;
    end
    chk("abort_nodone", 32'(dn), 32'd0);
    run_op("post_rst", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0);

    // Randomized operands, with bias toward corner divisors.
    for (int i = 0; i < 40; i++) begin
      s = 1'($urandom_range(0, 1));
      x = $urandom;
      case ($urandom_range(0, 6))
        0:       y = 32'd0;
        1:       y = 32'd1;
        2:       y = 32'hFFFF_FFFF;
        3:       y = 32'($urandom_range(1, 15));
        4:       y = -32'($urandom_range(1, 15));
        5: begin x = 32'h8000_0000; y = $urandom; end
        default: y = $urandom;
      endcase
      ref_div(s, x, y, q, rm, z);
      if ($urandom_range(0, 3) == 0) @(negedge clk);
      run_op("rand", s, x, y, q, rm, z);
    end

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multi-cycle 32-bit integer divider for the mMIPS datapath; it is the inverse counterpart of the ALU multiply path.
- Serves DIV and DIVU. The quotient goes to LO (r) and the remainder to HI (r2), which is the same result pairing the ALU uses for MULTU.
- Radix-2 restoring algorithm on magnitudes, with a final sign-fix step.
- Start/busy/done handshake lets the controller stall the pipeline until the result is written.

Parameters:
- WIDTH, 32, operand and result width; all numbers below assume 32.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a division; sampled only in IDLE.
- sgn  input  1  1 = signed (DIV), 0 = unsigned (DIVU); captured with start.
- a  input  32  dividend; captured with start.
- b  input  32  divisor; captured with start.
- busy  output  1  high while a division is in progress.
- done  output  1  one-cycle pulse; r, r2 and dz are valid from this cycle onward.
- r  output  32  quotient (LO).
- r2  output  32  remainder (HI).
- dz  output  1  divide-by-zero flag for the last completed operation.

Behaviour:
- Interface rule: one clock; reset is synchronous and active-high.
- Reset: on an edge with rst=1, go to IDLE and clear busy, done, r, r2, dz, the iteration counter and all internal registers to 0. This overrides start.
- States: IDLE, CALC, FIX.
- Edge E0 (IDLE, start=1): latch sgn, a and b.
  - Latch magnitudes: |a| and |b| when sgn=1; raw values when sgn=0.
  - Latch negq = sgn & (a[31]^b[31]) and negr = sgn & a[31].
  - Clear the partial remainder, load the counter with 31, set busy=1.
  - Go to CALC; if b==0, go to FIX directly.
- CALC, edges E1..E32: one restoring step per edge.
  - Shift {rem,quo} left by 1, bringing in the next dividend MSB.
  - Trial-subtract the divisor magnitude with a 33-bit subtract; if it is non-negative, keep the difference and set the quotient LSB to 1.
  - The counter decrements each edge; at counter==0 go to FIX.
- FIX, edge E33 (normal) or E1 (b==0):
  - r = negq ? -quo : quo.
  - r2 = negr ? -rem : rem.
  - dz = 0.
  - busy=0, done=1, go to IDLE.
- Divide by zero: r=32'hFFFFFFFF, r2=a (raw captured value), dz=1. The result is the same for signed and unsigned.
- Latency: done is high in the cycle after E33 (34 edges after start is sampled); for b==0 it is 2 edges.
- done is exactly one cycle wide and is cleared on the next edge.
- r, r2 and dz hold their values until the next FIX or reset.
- Signed semantics:
  - Quotient truncates toward zero; remainder takes the dividend's sign.
  - 32'h80000000 / -1 gives r=32'h80000000, r2=0 with no trap; magnitude 2^31 must be representable in the 32-bit unsigned path.
- start while busy=1 is ignored: no queueing and no effect on the operation in flight.
- start during the done cycle (state is IDLE) is accepted. busy rises on that edge and done falls.
- Operand changes after E0 have no effect.
- rst asserted mid-operation aborts it: no done pulse, and outputs are cleared per the reset rule.

Test Plan:
- Unsigned basic: sgn=0, a=100, b=7 → done exactly 34 edges after the start edge; r=14, r2=2, dz=0; busy high for 33 cycles.
- Signed sign matrix: a=-7 (32'hFFFFFFF9), b=2 → r=-3, r2=-1; a=7, b=-2 → r=-3, r2=1; a=-7, b=-2 → r=3, r2=-1.
- Corners: sgn=0, a=32'hFFFFFFFF, b=1 → r=32'hFFFFFFFF, r2=0; sgn=1, a=32'h80000000, b=32'hFFFFFFFF → r=32'h80000000, r2=0; sgn=0, a=5, b=9 → r=0, r2=5.
- Divide by zero: a=1234, b=0, each sgn value → done after 2 edges; r=32'hFFFFFFFF, r2=1234, dz=1. The next normal division clears dz.
- Handshake:
  - Pulse start again mid-operation with different operands; the result must match the first operands only.
  - Assert start in the done cycle; this must be accepted, and the second result must appear 34 edges later.
- Reset mid-operation: rst high at edge E10 → busy=0, r=r2=0, dz=0, and no done pulse ever appears. A following a=9, b=3 run gives r=3, r2=0.
